fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit_pkg.sv | 32 +++
 rtl/fetch_unit_if_id.sv | 37 +++
 rtl/fetch_unit.sv | 116 +++++++++++
 tb/tb_fetch_unit.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared fetch-stage definitions: reset PC, legal instruction window, nop
// word, IF/ID payload and fetch FSM encoding.
// Build option: DELAY_SLOT_EN (MIPS branch delay slot; drops the SQUASH state).
package fetch_unit_pkg;

   localparam logic [31:0] PC_RESET_DEF = 32'h0000_3000;
   localparam logic [31:0] IMEM_LO_DEF  = 32'h0000_3000;
   localparam logic [31:0] IMEM_HI_DEF  = 32'h0000_6FFC;
   localparam logic [31:0] NOP          = 32'h0000_0000;

`ifdef DELAY_SLOT_EN
   typedef enum logic [1:0] {
      RUN  = 2'd0,
      HOLD = 2'd1
   } fstate_t;
`else
   typedef enum logic [1:0] {
      RUN    = 2'd0,
      HOLD   = 2'd1,
      SQUASH = 2'd2
   } fstate_t;
`endif

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc4;
      logic [31:0] pc8;
      logic        valid;
      logic        adel;
   } ifid_t;

endpackage

// File: rtl/fetch_unit_if_id.sv
// IF/ID pipeline register. Hold wins over flush; flush loads a nop bubble
// but keeps the sequential PC+4/PC+8 so the bubble still has a sane PC.
module if_id_reg
   import fetch_unit_pkg::*;
#(
   parameter logic [31:0] PC_RESET = PC_RESET_DEF
) (
   input  logic  clk,
   input  logic  reset,
   input  logic  hold,
   input  logic  flush,
   input  ifid_t d,
   output ifid_t q
);

   // capture, hold or bubble the fetched instruction
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         q.instr <= NOP;
         q.pc4   <= PC_RESET + 32'd4;
         q.pc8   <= PC_RESET + 32'd8;
         q.valid <= 1'b0;
         q.adel  <= 1'b0;
      end else if (!hold) begin
         q.pc4 <= d.pc4;
         q.pc8 <= d.pc8;
         if (flush) begin
            q.instr <= NOP;
            q.valid <= 1'b0;
            q.adel  <= 1'b0;
         end else begin
            q <= d;
         end
      end
   end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register, prioritised next-PC mux, fetch
// address checking and the fetch FSM feeding the IF/ID register.
// Build option: DELAY_SLOT_EN keeps the instruction fetched in a redirect
// cycle (delay slot); otherwise that instruction is squashed to a nop.
module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter logic [31:0] PC_RESET = PC_RESET_DEF,
   parameter logic [31:0] IMEM_LO  = IMEM_LO_DEF,
   parameter logic [31:0] IMEM_HI  = IMEM_HI_DEF
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        StallF,
   input  logic        FlushD,
   input  logic        BranchTakenD,
   input  logic [31:0] PCBranchD,
   input  logic        JumpD,
   input  logic [31:0] PCJumpD,
   input  logic        JrD,
   input  logic [31:0] PCJrD,
   output logic [31:0] ImemAddr,
   input  logic [31:0] ImemRdata,
   output logic [31:0] InstrD,
   output logic [31:0] PC4D,
   output logic [31:0] PC8D,
   output logic        ValidD,
   output logic        AdELD
);

   logic [31:0] pc, pc4, pc8, pc_next;
   logic        adel, redirect, take, squash;
   fstate_t     state;
   ifid_t       ifid_d, ifid_q;

   assign pc4      = pc + 32'd4;
   assign pc8      = pc + 32'd8;
   assign adel     = (pc[1:0] != 2'b00) || (pc < IMEM_LO) || (pc > IMEM_HI);
   assign redirect = JrD | JumpD | BranchTakenD;

`ifdef DELAY_SLOT_EN
   assign take   = redirect & ~StallF;
   assign squash = FlushD;
`else
   // D holds a bubble during SQUASH, so any redirect seen then is spurious
   assign take   = redirect & ~StallF & (state != SQUASH);
   assign squash = FlushD | take;
`endif

   // next-PC select: jr > jump > branch > sequential
   always_comb begin
      pc_next = pc4;
      if (take) begin
         if (JrD)               pc_next = PCJrD;
         else if (JumpD)        pc_next = PCJumpD;
         else if (BranchTakenD) pc_next = PCBranchD;
      end
   end

   // program counter; stall freezes it and drops redirects
   always_ff @(posedge clk or posedge reset) begin
      if (reset)        pc <= PC_RESET;
      else if (!StallF) pc <= pc_next;
   end

   // fetch FSM
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= RUN;
      end else begin
         case (state)
            RUN: begin
               if (StallF) state <= HOLD;
`ifndef DELAY_SLOT_EN
               else if (take) state <= SQUASH;
`endif
            end
            HOLD: begin
               if (!StallF) begin
                  state <= RUN;
`ifndef DELAY_SLOT_EN
                  if (take) state <= SQUASH;
`endif
               end
            end
`ifndef DELAY_SLOT_EN
            SQUASH:  state <= StallF ? HOLD : RUN;
`endif
            default: state <= RUN;
         endcase
      end
   end

   assign ifid_d.instr = adel ? NOP : ImemRdata;
   assign ifid_d.pc4   = pc4;
   assign ifid_d.pc8   = pc8;
   assign ifid_d.valid = 1'b1;
   assign ifid_d.adel  = adel;

   if_id_reg #(.PC_RESET(PC_RESET)) u_if_id (
      .clk   (clk),
      .reset (reset),
      .hold  (StallF),
      .flush (squash),
      .d     (ifid_d),
      .q     (ifid_q)
   );

   assign ImemAddr = pc;
   assign InstrD   = ifid_q.instr;
   assign PC4D     = ifid_q.pc4;
   assign PC8D     = ifid_q.pc8;
   assign ValidD   = ifid_q.valid;
   assign AdELD    = ifid_q.adel;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: expected IF/ID contents are queued as each
// step is driven and compared after the following rising edge.
module tb_fetch_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        StallF, FlushD, BranchTakenD, JumpD, JrD;
   logic [31:0] PCBranchD, PCJumpD, PCJrD;
   logic [31:0] ImemAddr, ImemRdata, InstrD, PC4D, PC8D;
   logic        ValidD, AdELD;

`ifdef DELAY_SLOT_EN
   localparam bit DS = 1'b1;
`else
   localparam bit DS = 1'b0;
`endif

   typedef struct {
      string       tag;
      logic [31:0] addr;
      logic [31:0] instr;
      logic [31:0] pc4;
      logic        vld;
      logic        adel;
      logic        chk_pc;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   function automatic logic [31:0] mem(input logic [31:0] a);
      return {~a[15:0], a[15:0]};
   endfunction

   assign ImemRdata = mem(ImemAddr);

   always #5 clk = ~clk;

   fetch_unit dut (
      .clk(clk), .reset(reset), .StallF(StallF), .FlushD(FlushD),
      .BranchTakenD(BranchTakenD), .PCBranchD(PCBranchD),
      .JumpD(JumpD), .PCJumpD(PCJumpD), .JrD(JrD), .PCJrD(PCJrD),
      .ImemAddr(ImemAddr), .ImemRdata(ImemRdata), .InstrD(InstrD),
      .PC4D(PC4D), .PC8D(PC8D), .ValidD(ValidD), .AdELD(AdELD)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   task automatic exp_i(input string tag, input logic [31:0] addr, input logic [31:0] instr,
                        input logic [31:0] pc4, input logic vld, input logic adel);
      exp_t e;
      e.tag = tag; e.addr = addr; e.instr = instr; e.pc4 = pc4;
      e.vld = vld; e.adel = adel; e.chk_pc = 1'b1;
      exp_q.push_back(e);
   endtask

   task automatic exp_n(input string tag, input logic [31:0] addr);
      exp_t e;
      e.tag = tag; e.addr = addr; e.instr = 32'h0; e.pc4 = 32'h0;
      e.vld = 1'b0; e.adel = 1'b0; e.chk_pc = 1'b0;
      exp_q.push_back(e);
   endtask

   // redirect cycle: delay-slot instruction kept, or replaced by a bubble
   task automatic exp_r(input string tag, input logic [31:0] addr, input logic [31:0] instr,
                        input logic [31:0] pc4, input logic adel);
      if (DS) exp_i(tag, addr, instr, pc4, 1'b1, adel);
      else    exp_n(tag, addr);
   endtask

   task automatic tick();
      exp_t e;
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
         checks++;
         errors++;
         $error("FAIL sb_empty observed=%0d expected=1", exp_q.size());
      end else begin
         e = exp_q.pop_front();
         chk({e.tag, ".addr"},  ImemAddr, e.addr);
         chk({e.tag, ".instr"}, InstrD, e.instr);
         chk({e.tag, ".valid"}, {31'b0, ValidD}, {31'b0, e.vld});
         chk({e.tag, ".adel"},  {31'b0, AdELD}, {31'b0, e.adel});
         if (e.chk_pc) begin
            chk({e.tag, ".pc4"}, PC4D, e.pc4);
            chk({e.tag, ".pc8"}, PC8D, e.pc4 + 32'd4);
         end
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; StallF = 0; FlushD = 0; BranchTakenD = 0; JumpD = 0; JrD = 0;
      PCBranchD = 0; PCJumpD = 0; PCJrD = 0;
      @(posedge clk);
      #1;
      chk("rst.addr",  ImemAddr, 32'h3000);
      chk("rst.instr", InstrD, 32'h0);
      chk("rst.pc4",   PC4D, 32'h3004);
      chk("rst.pc8",   PC8D, 32'h3008);
      chk("rst.valid", {31'b0, ValidD}, 32'h0);
      chk("rst.adel",  {31'b0, AdELD}, 32'h0);
      reset = 1'b0;

      exp_i("seq1", 32'h3004, mem(32'h3000), 32'h3004, 1, 0); tick();
      exp_i("seq2", 32'h3008, mem(32'h3004), 32'h3008, 1, 0); tick();
      exp_i("seq3", 32'h300C, mem(32'h3008), 32'h300C, 1, 0); tick();
      exp_i("seq4", 32'h3010, mem(32'h300C), 32'h3010, 1, 0); tick();

      // stall with a redirect and flush present: all ignored
      StallF = 1; BranchTakenD = 1; PCBranchD = 32'h3040; FlushD = 1;
      for (int i = 0; i < 3; i++) begin
         exp_i("stall", 32'h3010, mem(32'h300C), 32'h3010, 1, 0); tick();
      end
      StallF = 0; BranchTakenD = 0; FlushD = 0;
      exp_i("resume", 32'h3014, mem(32'h3010), 32'h3014, 1, 0); tick();

      JumpD = 1; PCJumpD = 32'h3004;
      exp_r("jmp", 32'h3004, mem(32'h3014), 32'h3018, 0); tick();
      JumpD = 0;
      exp_i("jmp_tgt", 32'h3008, mem(32'h3004), 32'h3008, 1, 0); tick();

      BranchTakenD = 1; PCBranchD = 32'h3040;
      exp_r("br", 32'h3040, mem(32'h3008), 32'h300C, 0); tick();
      BranchTakenD = 0;
      exp_i("br_tgt", 32'h3044, mem(32'h3040), 32'h3044, 1, 0); tick();

      JrD = 1; PCJrD = 32'h3100; JumpD = 1; PCJumpD = 32'h3200;
      BranchTakenD = 1; PCBranchD = 32'h3300;
      exp_r("prio", 32'h3100, mem(32'h3044), 32'h3048, 0); tick();
      JrD = 0; JumpD = 0; BranchTakenD = 0;
      exp_i("prio_tgt", 32'h3104, mem(32'h3100), 32'h3104, 1, 0); tick();

      FlushD = 1;
      exp_n("flush", 32'h3108); tick();
      FlushD = 0;

      JrD = 1; PCJrD = 32'h3002;
      exp_r("jr_mis", 32'h3002, mem(32'h3108), 32'h310C, 0); tick();
      JrD = 0;
      exp_i("adel_mis", 32'h3006, 32'h0, 32'h3006, 1, 1); tick();

      JrD = 1; PCJrD = 32'h7000;
      exp_r("jr_hi", 32'h7000, 32'h0, 32'h300A, 1); tick();
      JrD = 0;
      exp_i("adel_hi", 32'h7004, 32'h0, 32'h7004, 1, 1); tick();

      JumpD = 1; PCJumpD = 32'h6FFC;
      exp_r("j_top", 32'h6FFC, 32'h0, 32'h7008, 1); tick();
      JumpD = 0;
      exp_i("top_ok", 32'h7000, mem(32'h6FFC), 32'h7000, 1, 0); tick();

      JumpD = 1; PCJumpD = 32'h2FFC;
      exp_r("j_low", 32'h2FFC, 32'h0, 32'h7004, 1); tick();
      JumpD = 0;
      exp_i("adel_lo", 32'h3000, 32'h0, 32'h3000, 1, 1); tick();

      JumpD = 1; PCJumpD = 32'hFFFF_FFFC;
      exp_r("j_wrap", 32'hFFFF_FFFC, mem(32'h3000), 32'h3004, 0); tick();
      JumpD = 0;
      exp_i("wrap", 32'h0, 32'h0, 32'h0, 1, 1); tick();
      exp_i("wrap2", 32'h4, 32'h0, 32'h4, 1, 1); tick();

      // reset mid-stall with a pending branch
      StallF = 1; BranchTakenD = 1; PCBranchD = 32'h3040;
      #2;
      reset = 1'b1;
      #1;
      chk("arst.addr",  ImemAddr, 32'h3000);
      chk("arst.valid", {31'b0, ValidD}, 32'h0);
      chk("arst.instr", InstrD, 32'h0);
      chk("arst.adel",  {31'b0, AdELD}, 32'h0);
      @(posedge clk);
      #1;
      reset = 1'b0; StallF = 0; BranchTakenD = 0;
      exp_i("post_rst", 32'h3004, mem(32'h3000), 32'h3004, 1, 0); tick();

      chk("sb_drained", exp_q.size(), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
